// File: rtl/updown_counter_param.sv
// updown_counter_param: bounded up/down/bounce counter with wrap or saturate, clamped load and terminal-count pulse
module updown_counter_param #(
  parameter int WIDTH   = 8,
  parameter int MIN     = 0,
  parameter int MAX     = 255,
  parameter int RST_VAL = 50
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mod,
  input  logic             wrap_en,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] count,
  output logic             dir,
  output logic             tc,
  output logic             at_max,
  output logic             at_min
);
  localparam logic [WIDTH-1:0] MN = WIDTH'(MIN);
  localparam logic [WIDTH-1:0] MX = WIDTH'(MAX);
  localparam logic [WIDTH-1:0] RV = WIDTH'(RST_VAL);
  logic [WIDTH-1:0] count_q, count_d;
  logic dir_q, dir_d, tc_q, tc_d, up, hit;
  assign up = mod == 2'd2 ? dir_q : mod[0];
  assign hit = up ? at_max : at_min;
  always_comb begin
    count_d = count_q;
    dir_d = dir_q;
    tc_d = 1'b0;
    if (load) count_d = din > MX ? MX : din < MN ? MN : din;
    else if (en && mod != 2'd3) begin
      tc_d = hit;
      dir_d = mod == 2'd2 ? dir_q ^ hit : up;
      count_d = !hit ? (up ? count_q + 1'b1 : count_q - 1'b1)
              : mod == 2'd2 ? (MN == MX ? count_q : up ? MX - 1'b1 : MN + 1'b1)
              : wrap_en ? (up ? MN : MX) : count_q;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= RV;
      dir_q <= 1'b1;
      tc_q <= 1'b0;
    end else begin
      count_q <= count_d;
      dir_q <= dir_d;
      tc_q <= tc_d;
    end
  end
  assign count = count_q;
  assign dir = dir_q;
  assign tc = tc_q;
  assign at_max = count_q == MX;
  assign at_min = count_q == MN;
endmodule

// File: tb/tb_updown_counter_param.sv
// tb_updown_counter_param: scoreboard bench with a behavioural counter model, directed plan plus random stimulus
module tb_updown_counter_param;
  localparam int MIN = 10, MAX = 60, RST_VAL = 50;
  typedef struct {int cnt; int dr; int t; int amax; int amin;} exp_t;
  logic clk = 0, rst = 0, en = 0, wrap_en = 0, load = 0;
  logic [1:0] mod = 0;
  logic [7:0] din = 0;
  logic [7:0] count;
  logic dir, tc, at_max, at_min;
  int n_chk = 0, n_fail = 0;
  int m_cnt = RST_VAL, m_dir = 1, m_tc = 0;
  exp_t q[$];
  updown_counter_param #(.WIDTH(8), .MIN(MIN), .MAX(MAX), .RST_VAL(RST_VAL)) dut (
    .clk(clk), .rst(rst), .en(en), .mod(mod), .wrap_en(wrap_en), .load(load), .din(din),
    .count(count), .dir(dir), .tc(tc), .at_max(at_max), .at_min(at_min)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic model(input bit l, input int d, input bit e, input int m, input bit w);
    int stp, nxt;
    if (l) begin
      m_cnt = d > MAX ? MAX : d < MIN ? MIN : d;
      m_tc = 0;
    end else if (!e || m == 3) m_tc = 0;
    else begin
      stp = m == 1 ? 1 : m == 0 ? -1 : (m_dir ? 1 : -1);
      nxt = m_cnt + stp;
      if (nxt >= MIN && nxt <= MAX) begin
        m_cnt = nxt;
        m_tc = 0;
      end else begin
        m_tc = 1;
        if (m == 2) begin
          m_dir = !m_dir;
          if (MIN != MAX) m_cnt = m_cnt - stp;
        end else if (w) m_cnt = stp > 0 ? MIN : MAX;
      end
      if (m != 2) m_dir = (m == 1);
    end
  endtask
  task automatic step(input bit l, input int d, input bit e, input int m, input bit w);
    exp_t x;
    load = l; din = 8'(d); en = e; mod = 2'(m); wrap_en = w;
    model(l, d, e, m, w);
    x.cnt = m_cnt; x.dr = m_dir; x.t = m_tc;
    x.amax = int'(m_cnt == MAX); x.amin = int'(m_cnt == MIN);
    q.push_back(x);
    @(negedge clk);
  endtask
  task automatic chk_reset(input string nm);
    chk({nm, "_count"}, int'(count), RST_VAL);
    chk({nm, "_dir"}, int'(dir), 1);
    chk({nm, "_tc"}, int'(tc), 0);
    chk({nm, "_at_max"}, int'(at_max), 0);
    chk({nm, "_at_min"}, int'(at_min), 0);
  endtask
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("count", int'(count), e.cnt);
      chk("dir", int'(dir), e.dr);
      chk("tc", int'(tc), e.t);
      chk("at_max", int'(at_max), e.amax);
      chk("at_min", int'(at_min), e.amin);
    end
  end
  initial begin
    #12;
    chk_reset("reset");
    @(negedge clk);
    rst = 1;
    for (int i = 0; i < 45; i++) step(0, 0, 1, 0, 1);
    chk("plan1_end", int'(count), 56);
    step(1, 58, 1, 1, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 1, 1, 0);
    chk("plan2_end", int'(count), 60);
    step(1, 58, 1, 2, 0);
    for (int i = 0; i < 6; i++) step(0, 0, 1, 2, $urandom_range(0, 1) == 1);
    chk("plan3_end", int'(count), 56);
    chk("plan3_dir", int'(dir), 0);
    step(1, 200, 1, 1, 0);
    step(1, 3, 1, 1, 0);
    chk("plan4_clamp", int'(count), 10);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 3, 1);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 1);
    step(1, 58, 1, 2, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 2, 0);
    #2 rst = 0;
    #1 chk_reset("async_reset");
    m_cnt = RST_VAL; m_dir = 1; m_tc = 0;
    @(negedge clk);
    chk_reset("reset_held");
    rst = 1;
    for (int i = 0; i < 600; i++) begin
      bit l = $urandom_range(0, 9) == 0;
      bit e = $urandom_range(0, 4) != 0;
      step(l, $urandom_range(0, 255), e, $urandom_range(0, 3), $urandom_range(0, 1) == 1);
    end
    @(negedge clk);
    chk("drain", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/updown_counter_param.md
# updown_counter_param

Parametrised up/down counter with programmable bounds, four counting modes (down, up, bounce, hold), wrap or saturate at the bounds, synchronous load with clamping, and a terminal-count pulse. It is the general-purpose successor to the fixed integer up/down counter. It serves as a timer, address sequencer or ping-pong index generator in sequential datapaths. All state is registered on `clk`.

## Interface
- `WIDTH`, 8: counter width in bits.
- `MIN`, 0: lower bound, inclusive.
- `MAX`, 255: upper bound, inclusive. Legal range: `MIN <= MAX <= 2^WIDTH-1`.
- `RST_VAL`, 50: count value after reset. Legal range: `MIN <= RST_VAL <= MAX`.
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `en`  in  1  count enable.
- `mod`  in  2  mode: 0 = down, 1 = up, 2 = bounce, 3 = hold.
- `wrap_en`  in  1  1 = wrap at bound, 0 = saturate at bound (modes 0/1 only).
- `load`  in  1  synchronous load of `din`.
- `din`  in  WIDTH  load value.
- `count`  out  WIDTH  current count.
- `dir`  out  1  current direction: 1 = up, 0 = down.
- `tc`  out  1  one-cycle terminal-count pulse.
- `at_max`  out  1  `count == MAX`.
- `at_min`  out  1  `count == MIN`.

## Operation
- **Reset (`rst` = 0, async):**
  - `count` = `RST_VAL`, `dir` = 1, `tc` = 0.
  - `at_max` and `at_min` follow from the decode of `RST_VAL`.
- **Priority per edge:** `load` > `en` > hold.
- **Load:**
  - `count` <= `din` clamped to [`MIN`, `MAX`]: `din > MAX` loads `MAX`, `din < MIN` loads `MIN`.
  - `dir` and `mode` are unaffected.
  - `tc` <= 0.
- **`en` = 0 and no load:** `count` and `dir` hold; `tc` <= 0.
- **mod = 1 (up):** `dir` <= 1.
  - `count < MAX`: `count+1`, `tc` <= 0.
  - `count == MAX`: `tc` <= 1; `count` <= `MIN` if `wrap_en`, else stays `MAX`.
  - `tc` repeats every enabled cycle while saturated.
- **mod = 0 (down):** `dir` <= 0.
  - `count > MIN`: `count-1`, `tc` <= 0.
  - `count == MIN`: `tc` <= 1; `count` <= `MAX` if `wrap_en`, else stays `MIN`.
- **mod = 2 (bounce):** `wrap_en` is ignored; stepping uses the stored `dir`.
  - `dir` = 1, `count < MAX`: `count+1`.
  - `dir` = 1, `count == MAX`: `dir` <= 0, `count` <= `MAX-1`, `tc` <= 1.
  - `dir` = 0, `count > MIN`: `count-1`.
  - `dir` = 0, `count == MIN`: `dir` <= 1, `count` <= `MIN+1`, `tc` <= 1.
  - `MIN == MAX`: `count` holds, `dir` toggles, `tc` <= 1.
- **mod = 3 (hold):** `count` and `dir` hold; `tc` <= 0.
- **Range invariant:** `count` never leaves [`MIN`, `MAX`]. Arithmetic is WIDTH bits with no internal overflow, since steps are taken only strictly inside the bounds.
- **Mode switch mid-count:** takes effect on the next enabled edge from the current `count`. Entering bounce uses the `dir` left by the previous mode.

## Timing
- `count`, `dir` and `tc` are registered: 1-cycle latency from inputs to outputs.
- `at_max` and `at_min` are combinational decodes of the `count` register; they are valid in the same cycle as `count`.
- `tc` is high for exactly the cycle following the bound event and is cleared by any non-bound edge.
- **Reset mid-operation:** outputs go to their reset values immediately, without waiting for `clk`. Counting resumes on the first rising edge after `rst` deasserts.
- Inputs are sampled only on the rising edge of `clk`; no input handshake.

## Test plan
All scenarios use `WIDTH`=8, `MIN`=10, `MAX`=60, `RST_VAL`=50.

1. **Reset and down count:** hold `rst`=0, then release; `en`=1, `mod`=0, `wrap_en`=1 for 45 edges -> `count` reads 50; steps down to 10 at edge 40; `tc`=1 and `count`=60 at edge 41; then 59, 58, 57, 56.
2. **Up saturate:** `load` `din`=58, then `mod`=1, `wrap_en`=0 for 5 edges -> `count` 59, 60, 60, 60, 60; `tc`=1 on the last three; `at_max`=1 from the second edge.
3. **Bounce:** `load` 58, `mod`=2, `dir`=1, 6 edges -> `count` 59, 60, 59, 58, 57, 56; `tc` pulses once, when 60 -> 59; `dir` 1 -> 0.
4. **Load clamp and priority:** with `en`=1 and `mod`=1, assert `load` with `din`=200, then `din`=3 -> `count`=60, then `count`=10; `tc`=0 on both.
5. **Hold and enable:** `mod`=3 for 3 edges, then `mod`=1 with `en`=0 for 3 edges -> `count` unchanged; `tc`=0 throughout.
6. **Async reset mid-count:** pull `rst` low between edges during scenario 3 -> `count`=50, `dir`=1, `tc`=0 before the next `clk` edge.
